// File: rtl/button_debounce_multi.sv
// N-channel push-button conditioner: 2-FF synchroniser, counter debounce,
// press/release/long-press single-cycle pulses and a wrapping press counter.
// Channels share parameters and the clear input but are otherwise independent.
// The debounced level is registered once more to produce the outputs. A clean
// step therefore appears on pressed and the pulses 2+STABLE_CYCLES edges after
// the edge that first samples it.
module button_debounce_multi #(
  parameter int N_CH          = 2,
  parameter int ACTIVE_LOW    = 1,
  parameter int STABLE_CYCLES = 500000,
  parameter int LONG_CYCLES   = 100000000,
  parameter int CNT_W         = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH-1:0]       button,
  input  logic                  clear_cnt,
  output logic [N_CH-1:0]       pressed,
  output logic [N_CH-1:0]       press_pulse,
  output logic [N_CH-1:0]       release_pulse,
  output logic [N_CH-1:0]       long_pulse,
  output logic [N_CH*CNT_W-1:0] press_count
);

  localparam int ST_W = $clog2(STABLE_CYCLES + 1);
  localparam int LG_W = $clog2(LONG_CYCLES + 1);

  // Last count value before an accepted level change.
  localparam logic [ST_W-1:0] ST_LAST = ST_W'(STABLE_CYCLES - 1);
  // Hold count on which long_pulse is armed, and the saturation value.
  localparam logic [LG_W-1:0] LG_FIRE = LG_W'(LONG_CYCLES - 1);
  localparam logic [LG_W-1:0] LG_MAX  = LG_W'(LONG_CYCLES);

  // XOR mask that turns the raw pin level into 1 = pressed.
  localparam logic [N_CH-1:0] POL = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

  // Valid/ready does not apply: every output is a plain registered level or
  // one-cycle pulse, consumed by the sink on the cycle it is high.

  logic [N_CH-1:0]            sync1_q, sync2_q;
  logic [N_CH-1:0]            deb_q, deb_d;
  logic [N_CH-1:0][ST_W-1:0]  stab_q, stab_d;
  logic [N_CH-1:0][LG_W-1:0]  hold_q, hold_d;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CH-1:0]            pressed_q, press_pulse_q, release_pulse_q, long_pulse_q;
  logic [N_CH-1:0]            long_d;

  // Two-stage synchroniser on the polarity-normalised input; resets to released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= button ^ POL;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: count consecutive disagreeing cycles, flip on the last one.
  always_comb begin
    deb_d  = deb_q;
    stab_d = stab_q;
    for (int i = 0; i < N_CH; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        stab_d[i] = '0;
      end else if (stab_q[i] == ST_LAST) begin
        deb_d[i]  = ~deb_q[i];
        stab_d[i] = '0;
      end else begin
        stab_d[i] = stab_q[i] + ST_W'(1);
      end
    end
  end

  // Hold counter next state: counts while pressed, saturates, arms long pulse once.
  always_comb begin
    hold_d = hold_q;
    long_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (!pressed_q[i]) begin
        hold_d[i] = '0;
      end else begin
        if (hold_q[i] != LG_MAX) begin
          hold_d[i] = hold_q[i] + LG_W'(1);
        end
        long_d[i] = (hold_q[i] == LG_FIRE);
      end
    end
  end

  // Press counter next state: clear wins over the increment from a press pulse.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_CH; i++) begin
      if (clear_cnt) begin
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(press_pulse_q[i]);
      end
    end
  end

  // Debounce state and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_q  <= '0;
      stab_q <= '0;
      hold_q <= '0;
      cnt_q  <= '0;
    end else begin
      deb_q  <= deb_d;
      stab_q <= stab_d;
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
    end
  end

  // Output registers: debounced level plus edge pulses against its previous value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pressed_q       <= '0;
      press_pulse_q   <= '0;
      release_pulse_q <= '0;
      long_pulse_q    <= '0;
    end else begin
      pressed_q       <= deb_q;
      press_pulse_q   <= deb_q & ~pressed_q;
      release_pulse_q <= ~deb_q & pressed_q;
      long_pulse_q    <= long_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;
  assign press_count   = cnt_q;

endmodule

// File: tb/tb_button_debounce_multi.sv
// Bench for button_debounce_multi: directed scenarios followed by a random
// bounce phase, all checked each cycle against a window-based reference model.
module tb_button_debounce_multi;

  localparam int N_CH   = 2;
  localparam int STABLE = 4;
  localparam int LONG   = 16;
  localparam int CNT_W  = 3;

  // Clock / reset / DUT
  logic                  clk;
  logic                  reset;
  logic [N_CH-1:0]       button;
  logic                  clear_cnt;
  logic [N_CH-1:0]       pressed, press_pulse, release_pulse, long_pulse;
  logic [N_CH*CNT_W-1:0] press_count;

  button_debounce_multi #(
    .N_CH(N_CH), .ACTIVE_LOW(1), .STABLE_CYCLES(STABLE),
    .LONG_CYCLES(LONG), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .button(button), .clear_cnt(clear_cnt),
    .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .press_count(press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard counters
  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: history of sampled (normalised) inputs, expected outputs.
  logic [N_CH-1:0]  hist[$];
  logic [N_CH-1:0]  m_deb, m_pressed, m_pp, m_rp, m_long;
  logic [CNT_W-1:0] m_cnt [N_CH];
  int               rise_edge [N_CH];
  int               edge_n = 0;

  // Observed tallies for directed checks
  int n_pp [N_CH];
  int n_rp [N_CH];
  int n_lg [N_CH];
  int pp_edge [N_CH];
  int rp_edge [N_CH];
  int lg_edge [N_CH];
  int rise_obs [N_CH];
  logic [N_CH-1:0] prev_obs;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int j = 0; j < STABLE + 2; j++) hist.push_back('0);
    m_deb = '0; m_pressed = '0; m_pp = '0; m_rp = '0; m_long = '0;
    for (int c = 0; c < N_CH; c++) begin
      m_cnt[c] = '0;
      rise_edge[c] = 0;
    end
  endtask

  // Model: a level change is accepted once the synchronised value has differed
  // from the accepted level over the whole last STABLE cycles; outputs follow
  // one edge later.
  task automatic model_step();
    logic [N_CH-1:0] x, old_deb, old_pr, old_pp;
    bit flip;
    if (reset) begin
      model_reset();
      return;
    end
    edge_n++;
    x = ~button;
    old_deb = m_deb; old_pr = m_pressed; old_pp = m_pp;
    for (int c = 0; c < N_CH; c++) begin
      flip = 1'b1;
      for (int j = 1; j <= STABLE; j++)
        if (hist[hist.size() - 1 - j][c] == old_deb[c]) flip = 1'b0;
      if (flip) m_deb[c] = ~old_deb[c];
      m_pressed[c] = old_deb[c];
      m_pp[c]      = old_deb[c] & ~old_pr[c];
      m_rp[c]      = ~old_deb[c] & old_pr[c];
      m_long[c]    = old_pr[c] && ((edge_n - rise_edge[c]) == LONG);
      if (m_pp[c]) rise_edge[c] = edge_n;
      m_cnt[c] = clear_cnt ? '0 : m_cnt[c] + CNT_W'(old_pp[c]);
    end
    hist.push_back(x);
    if (hist.size() > STABLE + 2) void'(hist.pop_front());
  endtask

  task automatic check_outputs();
    logic [N_CH*CNT_W-1:0] ev;
    for (int c = 0; c < N_CH; c++) ev[c*CNT_W +: CNT_W] = m_cnt[c];
    chk("pressed",       32'(pressed),       32'(m_pressed));
    chk("press_pulse",   32'(press_pulse),   32'(m_pp));
    chk("release_pulse", 32'(release_pulse), 32'(m_rp));
    chk("long_pulse",    32'(long_pulse),    32'(m_long));
    chk("press_count",   32'(press_count),   32'(ev));
    for (int c = 0; c < N_CH; c++) begin
      if (press_pulse[c] === 1'b1)   begin n_pp[c]++; pp_edge[c] = edge_n; end
      if (release_pulse[c] === 1'b1) begin n_rp[c]++; rp_edge[c] = edge_n; end
      if (long_pulse[c] === 1'b1)    begin n_lg[c]++; lg_edge[c] = edge_n; end
      if (pressed[c] === 1'b1 && prev_obs[c] !== 1'b1) rise_obs[c] = edge_n;
    end
    prev_obs = pressed;
  endtask

  task automatic clr_tally();
    for (int c = 0; c < N_CH; c++) begin
      n_pp[c] = 0; n_rp[c] = 0; n_lg[c] = 0;
      pp_edge[c] = 0; rp_edge[c] = 0; lg_edge[c] = 0; rise_obs[c] = 0;
    end
  endtask

  // Driver: one clock cycle; model advances on the edge, outputs checked mid-cycle.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_pressed"}, 32'(pressed),       32'd0);
    chk({tag, "_pp"},      32'(press_pulse),   32'd0);
    chk({tag, "_rp"},      32'(release_pulse), 32'd0);
    chk({tag, "_long"},    32'(long_pulse),    32'd0);
    chk({tag, "_count"},   32'(press_count),   32'd0);
  endtask

  // Called at a falling edge; asserts reset in the middle of the low phase.
  task automatic async_reset_now(string tag);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all_zero(tag);
    prev_obs = '0;
  endtask

  initial begin
    int e0, e1;
    bit seen;
    int run [N_CH];

    reset = 1'b0;
    button = '1;
    clear_cnt = 1'b0;
    prev_obs = '0;
    clr_tally();
    model_reset();

    // 1. Reset pulse, idle buttons, then 50 quiet cycles
    #1 reset = 1'b1;
    model_reset();
    #1 check_all_zero("rst_assert");
    tick(); tick();
    reset = 1'b0;
    clr_tally();
    repeat (50) tick();
    chk("idle_no_press_pulse", 32'(n_pp[0] + n_pp[1]), 32'd0);

    // 2. Short glitches on ch0 are rejected
    clr_tally();
    repeat (4) begin
      button[0] = 1'b0; repeat (2) tick();
      button[0] = 1'b1; repeat (20) tick();
    end
    chk("glitch_no_press", 32'(n_pp[0]), 32'd0);
    chk("glitch_count",    32'(press_count[CNT_W-1:0]), 32'd0);

    // 3. Clean press and release on ch0, latency 2+STABLE edges
    clr_tally();
    button[0] = 1'b0; tick(); e0 = edge_n; repeat (11) tick();
    button[0] = 1'b1; tick(); e1 = edge_n; repeat (11) tick();
    chk("clean_press_once",     32'(n_pp[0]), 32'd1);
    chk("clean_press_latency",  32'(pp_edge[0] - e0), 32'(STABLE + 2));
    chk("clean_release_once",   32'(n_rp[0]), 32'd1);
    chk("clean_release_latency", 32'(rp_edge[0] - e1), 32'(STABLE + 2));
    chk("clean_count",          32'(press_count[CNT_W-1:0]), 32'd1);

    // 4. Long press fires once, LONG cycles after pressed rises; short hold does not
    clr_tally();
    button[0] = 1'b0; repeat (30) tick();
    button[0] = 1'b1; repeat (15) tick();
    chk("long_once",   32'(n_lg[0]), 32'd1);
    chk("long_timing", 32'(lg_edge[0] - rise_obs[0]), 32'(LONG));
    clr_tally();
    button[0] = 1'b0; repeat (10) tick();
    button[0] = 1'b1; repeat (15) tick();
    chk("short_hold_no_long", 32'(n_lg[0]), 32'd0);
    chk("short_hold_press",   32'(n_pp[0]), 32'd1);

    // 5. Nine presses on ch1 wrap a 3-bit counter to 1; ch0 untouched
    repeat (9) begin
      button[1] = 1'b0; repeat (8) tick();
      button[1] = 1'b1; repeat (8) tick();
    end
    chk("wrap_counts", 32'(press_count), 32'({3'd1, 3'd3}));

    // 6a. clear_cnt coincident with a ch0 press pulse
    seen = 1'b0;
    button[0] = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (press_pulse[0] === 1'b1) begin
        seen = 1'b1;
        clear_cnt = 1'b1;
      end
    end
    chk("clr_pulse_seen", 32'(seen), 32'd1);
    tick();
    clear_cnt = 1'b0;
    chk("clr_count_zero", 32'(press_count), 32'd0);
    repeat (3) tick();
    chk("clr_count_stays", 32'(press_count), 32'd0);
    button[0] = 1'b1; repeat (12) tick();

    // 6b. Async reset while ch1 is held
    button[1] = 1'b0; repeat (14) tick();
    chk("hold_before_rst", 32'(pressed[1]), 32'd1);
    async_reset_now("rst_mid_hold");
    button[1] = 1'b1;
    tick(); tick();
    reset = 1'b0;
    clr_tally();
    repeat (20) tick();
    chk("post_rst_no_pulse", 32'(n_pp[0] + n_pp[1]), 32'd0);

    // Random bounce phase with occasional clears and one async reset
    for (int c = 0; c < N_CH; c++) run[c] = 0;
    for (int i = 0; i < 1500; i++) begin
      for (int c = 0; c < N_CH; c++) begin
        if (run[c] == 0) begin
          button[c] = ~button[c];
          run[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(4, 30));
        end
        run[c]--;
      end
      clear_cnt = ($urandom_range(0, 39) == 0);
      if (i == 700) begin
        async_reset_now("rst_random");
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end
    clear_cnt = 1'b0;
    button = '1;
    repeat (20) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
